// File: rtl/rob_alloc_pkg.sv
// Shared sizing, tag encoding and entry layout for the reorder-buffer allocator.
package rob_alloc_pkg;

   localparam int ENTRIES = 16;
   localparam int IDX_W   = 4;
   localparam int TAG_W   = 5;
   localparam int REG_W   = 5;
   localparam int DATA_W  = 32;

   localparam logic [TAG_W-1:0] TAG_INVALID = '1;

   typedef struct packed {
      logic              busy;
      logic              ready;
      logic              rd_en;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] val;
   } rob_entry_t;

   // Tags are the entry index zero-extended, so the all-ones tag never names an entry.
   function automatic logic [TAG_W-1:0] idx2tag(input logic [IDX_W-1:0] idx);
      return {{(TAG_W-IDX_W){1'b0}}, idx};
   endfunction

endpackage

// File: rtl/rob_ptr.sv
// Head/tail pointer pair with a wrap bit above the index, giving full/empty directly.
module rob_ptr #(
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc_head,
   input  logic             inc_tail,
   output logic [IDX_W-1:0] head_idx,
   output logic [IDX_W-1:0] tail_idx,
   output logic             full,
   output logic             empty
);

   logic [IDX_W:0] head;
   logic [IDX_W:0] tail;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (inc_head) head <= head + (IDX_W+1)'(1);
         if (inc_tail) tail <= tail + (IDX_W+1)'(1);
      end
   end

   assign head_idx = head[IDX_W-1:0];
   assign tail_idx = tail[IDX_W-1:0];
   assign empty    = (head == tail);
   // Same slot but different lap means the tail has caught the head from behind.
   assign full     = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);

endmodule

// File: rtl/rob_alloc.sv
// ROB tag allocator: grants tags to decode, captures CDB results, retires in order to the RF.
module rob_alloc
   import rob_alloc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              alloc_req,
   input  logic              alloc_rd_en,
   input  logic [REG_W-1:0]  alloc_rd,
   output logic [TAG_W-1:0]  avail_tag,
   output logic              full,
   output logic              empty,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_val,
   output logic              retire_valid,
   output logic              wb_en,
   output logic [REG_W-1:0]  wb_rd,
   output logic [TAG_W-1:0]  wb_tag,
   output logic [DATA_W-1:0] wb_val
);

   rob_entry_t       ent [ENTRIES];
   logic [IDX_W-1:0] head_idx;
   logic [IDX_W-1:0] tail_idx;
   logic [IDX_W-1:0] cdb_idx;
   logic             alloc_fire;
   logic             cdb_fire;
   logic             retire_fire;

   rob_ptr #(.IDX_W(IDX_W)) u_ptr (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush),
      .inc_head (retire_fire),
      .inc_tail (alloc_fire),
      .head_idx (head_idx),
      .tail_idx (tail_idx),
      .full     (full),
      .empty    (empty)
   );

   assign avail_tag  = full ? TAG_INVALID : idx2tag(tail_idx);
   assign alloc_fire = alloc_req && !full;

   // Upper tag bits must be zero: this rejects TAG_INVALID and any other non-entry tag.
   assign cdb_idx  = cdb_tag[IDX_W-1:0];
   assign cdb_fire = cdb_valid && (cdb_tag[TAG_W-1:IDX_W] == '0) &&
                     ent[cdb_idx].busy && !ent[cdb_idx].ready;

   assign retire_fire = ent[head_idx].busy && ent[head_idx].ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ent[i].busy  <= 1'b0;
            ent[i].ready <= 1'b0;
         end
      end else begin
         // Retire and alloc never share a slot: alloc needs !full, retire needs a busy head.
         if (retire_fire) begin
            ent[head_idx].busy  <= 1'b0;
            ent[head_idx].ready <= 1'b0;
         end
         if (alloc_fire) begin
            ent[tail_idx].busy  <= 1'b1;
            ent[tail_idx].ready <= 1'b0;
            ent[tail_idx].rd_en <= alloc_rd_en;
            ent[tail_idx].rd    <= alloc_rd;
         end
         if (cdb_fire) begin
            ent[cdb_idx].ready <= 1'b1;
            ent[cdb_idx].val   <= cdb_val;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         retire_valid <= 1'b0;
         wb_en        <= 1'b0;
         wb_rd        <= '0;
         wb_tag       <= TAG_INVALID;
         wb_val       <= '0;
      end else if (flush) begin
         retire_valid <= 1'b0;
         wb_en        <= 1'b0;
      end else begin
         retire_valid <= retire_fire;
         // r0 is hardwired, so a retire to it never writes the register file.
         wb_en        <= retire_fire && ent[head_idx].rd_en && (ent[head_idx].rd != '0);
         if (retire_fire) begin
            wb_rd  <= ent[head_idx].rd;
            wb_tag <= idx2tag(head_idx);
            wb_val <= ent[head_idx].val;
         end
      end
   end

endmodule

// File: tb/tb_rob_alloc.sv
// Directed bench for rob_alloc with hand-computed expectations.
module tb_rob_alloc;
   import rob_alloc_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              flush = 1'b0;
   logic              alloc_req = 1'b0;
   logic              alloc_rd_en = 1'b0;
   logic [REG_W-1:0]  alloc_rd = '0;
   logic [TAG_W-1:0]  avail_tag;
   logic              full;
   logic              empty;
   logic              cdb_valid = 1'b0;
   logic [TAG_W-1:0]  cdb_tag = '0;
   logic [DATA_W-1:0] cdb_val = '0;
   logic              retire_valid;
   logic              wb_en;
   logic [REG_W-1:0]  wb_rd;
   logic [TAG_W-1:0]  wb_tag;
   logic [DATA_W-1:0] wb_val;

   int total = 0;
   int bad   = 0;

   rob_alloc dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .alloc_req    (alloc_req),
      .alloc_rd_en  (alloc_rd_en),
      .alloc_rd     (alloc_rd),
      .avail_tag    (avail_tag),
      .full         (full),
      .empty        (empty),
      .cdb_valid    (cdb_valid),
      .cdb_tag      (cdb_tag),
      .cdb_val      (cdb_val),
      .retire_valid (retire_valid),
      .wb_en        (wb_en),
      .wb_rd        (wb_rd),
      .wb_tag       (wb_tag),
      .wb_val       (wb_val)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic alloc(input logic en, input logic [REG_W-1:0] rd);
      alloc_req = 1'b1; alloc_rd_en = en; alloc_rd = rd;
      step();
      alloc_req = 1'b0;
   endtask

   task automatic cdb(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
      cdb_valid = 1'b1; cdb_tag = t; cdb_val = v;
      step();
      cdb_valid = 1'b0;
   endtask

   initial begin
      // reset
      rst = 1'b1; step(); step(); rst = 1'b0;
      chk("rst_full", full, 0);
      chk("rst_empty", empty, 1);
      chk("rst_avail", avail_tag, 0);
      chk("rst_rv", retire_valid, 0);
      chk("rst_wben", wb_en, 0);
      chk("rst_wbtag", wb_tag, 5'h1F);
      chk("rst_wbrd", wb_rd, 0);
      chk("rst_wbval", wb_val, 0);

      // fill all 16 entries
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("fill_avail%0d", i), avail_tag, i);
         alloc(1'b1, REG_W'(i + 1));
      end
      chk("fill_full", full, 1);
      chk("fill_avail_inv", avail_tag, 5'h1F);
      chk("fill_empty", empty, 0);
      alloc(1'b1, 5'd20);
      chk("drop_full", full, 1);
      chk("drop_avail", avail_tag, 5'h1F);
      chk("drop_rv", retire_valid, 0);

      // full with head ready: retire frees a slot, alloc_req that cycle is dropped
      cdb(5'd0, 32'h55);
      chk("fullret_rv0", retire_valid, 0);
      alloc_req = 1'b1; alloc_rd_en = 1'b1; alloc_rd = 5'd21;
      step();
      chk("fullret_rv", retire_valid, 1);
      chk("fullret_wben", wb_en, 1);
      chk("fullret_rd", wb_rd, 1);
      chk("fullret_tag", wb_tag, 0);
      chk("fullret_val", wb_val, 32'h55);
      chk("fullret_full", full, 0);
      chk("fullret_avail", avail_tag, 0);
      step();
      alloc_req = 1'b0;
      chk("wrap_full", full, 1);
      chk("wrap_avail", avail_tag, 5'h1F);
      chk("wrap_rv", retire_valid, 0);
      flush = 1'b1; step(); flush = 1'b0;
      chk("fl1_empty", empty, 1);
      chk("fl1_avail", avail_tag, 0);

      // out-of-order completion, in-order retire
      alloc(1'b1, 5'd3);
      alloc(1'b1, 5'd4);
      alloc(1'b1, 5'd5);
      chk("ooo_avail", avail_tag, 3);
      cdb(5'd2, 32'hC);
      chk("ooo_rv_a", retire_valid, 0);
      cdb(5'd0, 32'hA);
      chk("ooo_rv_b", retire_valid, 0);
      cdb(5'd1, 32'hB);
      chk("ooo_rv0", retire_valid, 1);
      chk("ooo_en0", wb_en, 1);
      chk("ooo_rd0", wb_rd, 3);
      chk("ooo_tag0", wb_tag, 0);
      chk("ooo_val0", wb_val, 32'hA);
      step();
      chk("ooo_rd1", wb_rd, 4);
      chk("ooo_tag1", wb_tag, 1);
      chk("ooo_val1", wb_val, 32'hB);
      step();
      chk("ooo_rd2", wb_rd, 5);
      chk("ooo_tag2", wb_tag, 2);
      chk("ooo_val2", wb_val, 32'hC);
      chk("ooo_empty", empty, 1);
      step();
      chk("ooo_rv_end", retire_valid, 0);
      chk("ooo_en_end", wb_en, 0);
      chk("ooo_rd_hold", wb_rd, 5);

      // flush beats simultaneous alloc and CDB
      for (int i = 0; i < 4; i++) alloc(1'b1, 5'd7);
      chk("pre_fl_avail", avail_tag, 7);
      flush = 1'b1; alloc_req = 1'b1; alloc_rd_en = 1'b1; alloc_rd = 5'd7;
      cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_val = 32'hDEAD;
      step();
      flush = 1'b0; alloc_req = 1'b0; cdb_valid = 1'b0;
      chk("fl2_empty", empty, 1);
      chk("fl2_avail", avail_tag, 0);
      chk("fl2_rv", retire_valid, 0);
      for (int i = 0; i < 4; i++) begin
         cdb(TAG_W'(3 + i), 32'h100 + i);
         chk($sformatf("fl2_wben%0d", i), wb_en, 0);
      end
      chk("fl2_empty_end", empty, 1);

      // ignored broadcasts, and retires that do not write
      cdb(5'd7, 32'h99);
      chk("free_rv", retire_valid, 0);
      chk("free_empty", empty, 1);
      cdb(5'h1F, 32'h98);
      chk("inv_rv", retire_valid, 0);
      chk("inv_avail", avail_tag, 0);
      alloc(1'b0, 5'd9);
      alloc(1'b1, 5'd0);
      cdb(5'd0, 32'h1);
      cdb(5'd0, 32'h77);
      chk("nowb_rv0", retire_valid, 1);
      chk("nowb_en0", wb_en, 0);
      chk("nowb_rd0", wb_rd, 9);
      chk("nowb_val0", wb_val, 32'h1);
      cdb(5'd1, 32'h2);
      chk("nowb_rv_gap", retire_valid, 0);
      step();
      chk("nowb_rv1", retire_valid, 1);
      chk("nowb_en1", wb_en, 0);
      chk("nowb_rd1", wb_rd, 0);
      chk("nowb_tag1", wb_tag, 1);
      chk("nowb_val1", wb_val, 32'h2);

      // reset mid-flight with a ready head
      alloc(1'b1, 5'd10);
      alloc(1'b1, 5'd11);
      alloc(1'b1, 5'd12);
      cdb(5'd2, 32'h5);
      rst = 1'b1; step(); rst = 1'b0;
      chk("mrst_rv", retire_valid, 0);
      chk("mrst_wben", wb_en, 0);
      chk("mrst_wbrd", wb_rd, 0);
      chk("mrst_wbtag", wb_tag, 5'h1F);
      chk("mrst_wbval", wb_val, 0);
      chk("mrst_empty", empty, 1);
      chk("mrst_full", full, 0);
      chk("mrst_avail", avail_tag, 0);
      step();
      chk("mrst_rv2", retire_valid, 0);
      chk("mrst_wben2", wb_en, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rob_alloc.md
Name: rob_alloc

Overview:
- Reorder buffer tag allocator and in-order retire unit.
- It is the responder side of the decode stage's ROB-position request: it supplies the next free tag, accepts allocations, and captures results from the common data bus (CDB).
- It retires entries in program order and drives register-file writeback with the value and its tag, so the register file clears a rename only if the tag still matches.

Parameters:
ENTRIES, 16, number of ROB entries (power of two)
IDX_W, 4, log2(ENTRIES)
TAG_W, 5, tag width; valid tags are {1'b0, index}; TAG_INVALID = all ones
REG_W, 5, architectural register index width
DATA_W, 32, result width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush  in  1  discard all in-flight entries (mispredict)
alloc_req  in  1  decode requests a tag this cycle
alloc_rd_en  in  1  allocated instruction writes a register
alloc_rd  in  REG_W  destination register of allocated instruction
avail_tag  out  TAG_W  tag granted if alloc_req this cycle; TAG_INVALID when full
full  out  1  no free entry
empty  out  1  no occupied entry
cdb_valid  in  1  result broadcast valid
cdb_tag  in  TAG_W  tag of broadcast result
cdb_val  in  DATA_W  broadcast result
retire_valid  out  1  one entry retired (registered)
wb_en  out  1  register write at retire (registered)
wb_rd  out  REG_W  retired destination register
wb_tag  out  TAG_W  retired tag
wb_val  out  DATA_W  retired value

Behaviour:
- Storage: per entry busy, ready, rd_en, rd, val. Head and tail pointers are IDX_W+1 bits, with the MSB as the wrap bit.
- empty = (head == tail). full = index bits equal and wrap bits differ.
- avail_tag = full ? TAG_INVALID : {1'b0, tail[IDX_W-1:0]}. This output is combinational from registered state.
- Allocation:
  - Fires when alloc_req && !full.
  - At the edge, the entry at tail gets busy=1, ready=0, rd_en, rd, and tail increments, wrapping and toggling the MSB.
  - alloc_req while full is dropped. Decode stalls on full.
- CDB capture:
  - Fires when cdb_valid and cdb_tag is non-invalid, and the indexed entry is busy and not ready.
  - At the edge it sets ready=1 and val=cdb_val.
  - Otherwise the broadcast is ignored: stale tag, free entry, or already ready.
- Retire:
  - Evaluated on registered state. If the head entry is busy and ready, at the edge: retire_valid=1; wb_en=rd_en && (rd != 0); wb_rd, wb_tag and wb_val are taken from that entry; the entry's busy is cleared; head increments.
  - Otherwise retire_valid=0 and wb_en=0. wb_rd, wb_tag and wb_val hold their values.
  - At most one retire per cycle. No CDB-to-retire bypass: a CDB result in cycle N gives wb_en high in cycle N+2 at the earliest.
- Simultaneous events:
  - Allocate and retire in the same cycle are both performed.
  - full is based on pre-edge state, so a retire at full does not enable allocation in the same cycle.
  - A CDB write and an allocation may target different entries in the same cycle. They cannot hit the same entry, because an allocated entry is not busy beforehand.
- flush (priority over alloc, CDB and retire): at the edge, head=tail=0, all busy and ready cleared, retire_valid=0, wb_en=0. Effective the next cycle.
- Reset values: head=tail=0; all busy/ready=0; retire_valid=0; wb_en=0; wb_rd=0; wb_tag=TAG_INVALID; wb_val=0; hence full=0, empty=1, avail_tag=0.
- A reset asserted mid-operation behaves identically to flush and additionally clears the wb_* data registers.

Decomposition:
- Shared package: TAG_W, TAG_INVALID, REG_W, DATA_W, ENTRIES; entry struct {busy, ready, rd_en, rd, val}.
- One natural sub-module: rob_ptr, a wrap-bit pointer pair giving full/empty and increments. It is instantiated once for head/tail management; the entry array stays in rob_alloc.

Test Plan:
- Reset, then 16 alloc_req cycles with rd=1..16 (mod 32) → avail_tag 0..15 in sequence; full=1 after the 16th; avail_tag=5'h1F; a 17th request leaves tail unchanged.
- Allocate tags 0,1,2 (rd=3,4,5); CDB tag 2 val 0xC, then tag 0 val 0xA, then tag 1 val 0xB → retires in order 0,1,2 with wb_rd 3,4,5 and wb_val 0xA,0xB,0xC; first wb_en two cycles after the tag-0 CDB.
- Full ROB with head ready, alloc_req asserted → retire occurs, no allocation that cycle; next cycle allocation granted tag 0 (wrap); tail wrap bit toggles; full stays consistent.
- Allocate 4 entries, flush together with alloc_req and cdb_valid → next cycle empty=1, avail_tag=0, wb_en never asserts for flushed entries.
- CDB with tag 7 when entry 7 is free, and with TAG_INVALID → no state change and no retire; entry with rd_en=0 or rd=0 retires with retire_valid=1, wb_en=0.
- Assert rst while 3 entries wait, one ready → following cycle all outputs at reset values; no wb_en issued.
